// File: rtl/noc_bridge_narrow_wide_pkg.sv
// rtl/noc_bridge_narrow_wide_pkg.sv - shared channel header, credit type and credit depths for the narrow/wide bridge
package noc_bridge_narrow_wide_pkg;

  // Channel header carried in bridge packets; value 3 is unused.
  typedef enum logic [1:0] {
    narrow_response = 2'd0,
    narrow_request  = 2'd1,
    wide_channel    = 2'd2
  } channel_hdr_e;

  typedef logic [7:0] bridge_credit_t;

  localparam int unsigned NumCred_NocBridgeNarrowReq = 20;
  localparam int unsigned NumCred_NocBridgeNarrowRsp = 20;
  localparam int unsigned NumCred_NocBridgeWide      = 20;

endpackage

// File: rtl/noc_bridge_credit_counter.sv
// rtl/noc_bridge_credit_counter.sv - credit up/down counter with same-cycle net add/subtract
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (loads InitVal)
//   inc_i         : amount added this cycle
//   dec_i         : amount subtracted this cycle
//   cnt_o         : current count
module noc_bridge_credit_counter
  import noc_bridge_narrow_wide_pkg::*;
#(
  parameter bridge_credit_t InitVal = '0,
  parameter bridge_credit_t MaxVal  = '0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  bridge_credit_t inc_i,
  input  bridge_credit_t dec_i,
  output bridge_credit_t cnt_o
);

  bridge_credit_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + inc_i - dec_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= InitVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  // An underflow wraps to a large value, so one upper-bound check covers both directions.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (cnt_q <= MaxVal)
        else $error("credit counter %0d above limit %0d", cnt_q, MaxVal);
    end
  end

endmodule

// File: rtl/noc_bridge_vc_scheduler.sv
// rtl/noc_bridge_vc_scheduler.sv - credit-based virtual channel scheduler for the narrow/wide bridge
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   chan_valid_i[3]     : per-channel flit pending (index = channel_hdr_e)
//   chan_ready_o[3]     : one-hot flit accept, handshake cycle only
//   slot_free_i[3]      : local RX slot freed, one credit owed to remote
//   rx_cred_*           : credits returned by the remote side
//   tx_valid_o/ready_i  : outgoing packet handshake
//   tx_data_hdr_o       : channel of the data flit
//   tx_data_validity_o  : packet carries a data flit
//   tx_credits_hdr_o/tx_credits_o : piggybacked credit return
module noc_bridge_vc_scheduler
  import noc_bridge_narrow_wide_pkg::*;
#(
  parameter int unsigned NumCredNarrowReq = NumCred_NocBridgeNarrowReq,
  parameter int unsigned NumCredNarrowRsp = NumCred_NocBridgeNarrowRsp,
  parameter int unsigned NumCredWide      = NumCred_NocBridgeWide
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [2:0]     chan_valid_i,
  output logic [2:0]     chan_ready_o,
  input  logic [2:0]     slot_free_i,
  input  logic           rx_cred_valid_i,
  input  logic [1:0]     rx_cred_hdr_i,
  input  bridge_credit_t rx_cred_i,
  output logic           tx_valid_o,
  input  logic           tx_ready_i,
  output logic [1:0]     tx_data_hdr_o,
  output logic           tx_data_validity_o,
  output logic [1:0]     tx_credits_hdr_o,
  output bridge_credit_t tx_credits_o
);

  typedef enum logic {st_idle, st_hold} state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q;
  bridge_credit_t tx_cred [3];
  bridge_credit_t ret_cnt [3];
  bridge_credit_t tx_inc [3];
  bridge_credit_t tx_dec [3];
  bridge_credit_t ret_inc [3];
  bridge_credit_t ret_dec [3];
  logic [2:0]     elig;

  logic           live_valid, live_dv;
  channel_hdr_e   live_dhdr, live_chdr;
  bridge_credit_t live_cred;

  logic           hold_dv_q;
  channel_hdr_e   hold_dhdr_q, hold_chdr_q;
  bridge_credit_t hold_cred_q;

  logic           sel_valid, sel_dv;
  channel_hdr_e   sel_dhdr, sel_chdr;
  bridge_credit_t sel_cred;
  logic           hs;

  // Live packet selection from the current counters.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    live_dv   = 1'b0;
    live_dhdr = narrow_response;
    live_cred = '0;
    live_chdr = narrow_response;
    for (int c = 0; c < 3; c++) begin
      elig[c] = chan_valid_i[c] && (tx_cred[c] != '0);
    end
    // Round-robin scan starting at the priority pointer.
    for (int k = 0; k < 3; k++) begin
      idx = 2'((int'(ptr_q) + k) % 3);
      if (!live_dv && elig[idx]) begin
        live_dv   = 1'b1;
        live_dhdr = channel_hdr_e'(idx);
      end
    end
    // Strict compare keeps the lowest index on ties.
    for (int c = 0; c < 3; c++) begin
      if (ret_cnt[c] > live_cred) begin
        live_cred = ret_cnt[c];
        live_chdr = channel_hdr_e'(c);
      end
    end
    live_valid = live_dv || (live_cred != '0);
  end

  // FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: if (live_valid && !tx_ready_i) state_d = st_hold;
      st_hold: if (tx_ready_i) state_d = st_idle;
      default: state_d = st_idle;
    endcase
  end

  // FSM: outputs. HOLD replays the packet captured on entry.
  always_comb begin
    sel_valid = live_valid;
    sel_dv    = live_dv;
    sel_dhdr  = live_dhdr;
    sel_chdr  = live_chdr;
    sel_cred  = live_cred;
    if (state_q == st_hold) begin
      sel_valid = 1'b1;
      sel_dv    = hold_dv_q;
      sel_dhdr  = hold_dhdr_q;
      sel_chdr  = hold_chdr_q;
      sel_cred  = hold_cred_q;
    end
  end

  // Capture every idle cycle; the value on the cycle HOLD is entered is the one kept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_dv_q   <= 1'b0;
      hold_dhdr_q <= narrow_response;
      hold_chdr_q <= narrow_response;
      hold_cred_q <= '0;
    end else if (state_q == st_idle) begin
      hold_dv_q   <= live_dv;
      hold_dhdr_q <= live_dhdr;
      hold_chdr_q <= live_chdr;
      hold_cred_q <= live_cred;
    end
  end

  // Reset gates the outputs so a held packet vanishes immediately.
  assign hs                 = rst_ni && sel_valid && tx_ready_i;
  assign tx_valid_o         = rst_ni && sel_valid;
  assign tx_data_validity_o = rst_ni && sel_dv;
  assign tx_data_hdr_o      = rst_ni ? sel_dhdr : 2'd0;
  assign tx_credits_hdr_o   = rst_ni ? sel_chdr : 2'd0;
  assign tx_credits_o       = rst_ni ? sel_cred : '0;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      chan_ready_o[c] = hs && sel_dv && (sel_dhdr == channel_hdr_e'(c));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 2'd0;
    end else if (hs && sel_dv) begin
      ptr_q <= (sel_dhdr == wide_channel) ? 2'd0 : 2'(sel_dhdr + 2'd1);
    end
  end

  // Counter update terms; header 3 never matches a channel so it is dropped.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      tx_inc[c]  = (rx_cred_valid_i && (rx_cred_hdr_i == 2'(c))) ? rx_cred_i : '0;
      tx_dec[c]  = (hs && sel_dv && (sel_dhdr == channel_hdr_e'(c))) ? 8'd1 : 8'd0;
      ret_inc[c] = slot_free_i[c] ? 8'd1 : 8'd0;
      ret_dec[c] = (hs && (sel_chdr == channel_hdr_e'(c))) ? sel_cred : '0;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    localparam bridge_credit_t NumCred = bridge_credit_t'((c == 0) ? NumCredNarrowRsp :
                                                          (c == 1) ? NumCredNarrowReq :
                                                                     NumCredWide);
    noc_bridge_credit_counter #(
      .InitVal(NumCred),
      .MaxVal (NumCred)
    ) u_tx_cred (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (tx_inc[c]),
      .dec_i (tx_dec[c]),
      .cnt_o (tx_cred[c])
    );
    noc_bridge_credit_counter #(
      .InitVal('0),
      .MaxVal (NumCred)
    ) u_ret_cnt (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .inc_i (ret_inc[c]),
      .dec_i (ret_dec[c]),
      .cnt_o (ret_cnt[c])
    );
  end

endmodule

// File: doc/noc_bridge_vc_scheduler.md
NOC_BRIDGE_VC_SCHEDULER -- requirements
Module: noc_bridge_vc_scheduler

Interface
REQ-001 SHALL have parameter NumCredNarrowReq, default 20: initial TX credits and max RX return count, narrow request channel.
REQ-002 SHALL have parameter NumCredNarrowRsp, default 20: same, narrow response channel.
REQ-003 SHALL have parameter NumCredWide, default 20: same, wide channel.
REQ-004 SHALL have ports, clock and reset first; channel index = channel_hdr_e value (0 narrow_response, 1 narrow_request, 2 wide_channel):
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- chan_valid_i  in  3  per-channel flit pending
- chan_ready_o  out  3  one-hot; flit of that channel accepted this cycle
- slot_free_i  in  3  per-channel pulse: local RX buffer freed one slot, credit owed to remote
- rx_cred_valid_i  in  1  received packet carries credits
- rx_cred_hdr_i  in  2  channel_hdr_e of received credits
- rx_cred_i  in  bridge_credit_t  received credit amount
- tx_valid_o  out  1  AXIS packet valid
- tx_ready_i  in  1  AXIS packet ready
- tx_data_hdr_o  out  2  channel_hdr_e of granted data
- tx_data_validity_o  out  1  packet carries a data flit
- tx_credits_hdr_o  out  2  channel_hdr_e of piggybacked credits
- tx_credits_o  out  bridge_credit_t  piggybacked credit count

Function
REQ-005 SHALL keep per-channel TX credit counter (bridge_credit_t), reset to its NumCred* value.
REQ-006 SHALL treat a channel as eligible when chan_valid_i[c]=1 and its TX credit >0.
REQ-007 SHALL select among eligible channels round-robin; priority pointer starts at channel 0, advances to granted+1 (mod 3) on each data handshake only.
REQ-008 SHALL keep per-channel return counter, reset 0, +1 per slot_free_i pulse.
REQ-009 SHALL select credit channel as the one with largest nonzero return count; ties to lowest index; tx_credits_o = full count of that channel; if all zero, tx_credits_o=0, tx_credits_hdr_o=0.
REQ-010 SHALL assert tx_valid_o when any channel is eligible or any return count is nonzero; tx_data_validity_o=1 only if a channel is eligible.
REQ-011 SHALL implement FSM IDLE/HOLD: IDLE computes selection combinationally; tx_valid_o=1 and tx_ready_i=0 -> HOLD; HOLD freezes all tx_* outputs until tx_ready_i=1 -> IDLE.
REQ-012 SHALL, in HOLD, not add late-arriving return credits or newly eligible channels to the frozen packet.
REQ-013 SHALL pulse chan_ready_o[g] only on the handshake cycle (tx_valid_o & tx_ready_i & tx_data_validity_o); same cycle TX credit[g] -1.
REQ-014 SHALL on handshake subtract tx_credits_o from the selected return counter; a same-cycle slot_free_i on that channel nets (+1 - sent).
REQ-015 SHALL add rx_cred_i to TX credit[rx_cred_hdr_i] when rx_cred_valid_i=1; simultaneous decrement nets in one cycle.
REQ-016 SHALL ignore rx_cred_hdr_i=3 (no counter change).
REQ-017 SHALL flag (simulation assertion) TX credit exceeding its NumCred* or return count exceeding its NumCred*.
REQ-018 SHALL have zero-cycle latency chan_valid_i -> tx_valid_o in IDLE; no combinational path tx_ready_i -> tx_valid_o.

Reset
REQ-019 SHALL on rst_ni=0 force: FSM IDLE, pointer 0, TX credits = NumCred*, return counts 0, tx_valid_o=0, chan_ready_o=0, all tx_* fields 0.
REQ-020 SHALL drop a held packet on reset mid-HOLD; no chan_ready_o pulse for it.

Structure
REQ-021 SHALL take channel_hdr_e, bridge_credit_t and NumCred_NocBridge* from noc_bridge_narrow_wide_pkg; add nothing new to it.
REQ-022 SHALL instantiate one sub-module, noc_bridge_credit_counter (per-channel up/down counter with net add/sub), three TX and three return instances.

Verification
REQ-023 Reset, all chan_valid_i=1, tx_ready_i=1 -> grants 0,1,2,0,... one per cycle; tx_data_validity_o=1.
REQ-024 Only wide valid, NumCredWide=20, no rx credits -> exactly 20 wide handshakes, then tx_valid_o=0.
REQ-025 Three slot_free_i[1] pulses, no data pending -> credit-only packet, tx_credits_hdr_o=1, tx_credits_o=3, tx_data_validity_o=0; count 0 after handshake.
REQ-026 tx_ready_i=0 for 5 cycles while slot_free_i pulses -> tx_* stable all 5 cycles; extra credits sent in next packet.
REQ-027 Wide credit 0, rx_cred_valid_i=1, hdr=2, rx_cred_i=4 plus same-cycle wide handshake impossible -> credit becomes 4; next cycle wide eligible.
REQ-028 rst_ni low during HOLD -> all outputs 0 asynchronously; credits back to 20.
